uart_rx_sequencer: RTL and testbench

Sequencing controller for the UART receive path. It oversamples the serial line, validates the start bit, and mid-samples the data, parity and stop bits, shifting LSB first. Completed characters are presented on a valid/ready handshake, with frame, parity and overrun status. It sits between the baud-tick generator and the receive buffer/host interface.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive sequencer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int MAX_DATA_BITS  = 9;

  function automatic int samp_cnt_width(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

  function automatic int bit_cnt_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  localparam int SAMP_CNT_W = samp_cnt_width(DEF_OVERSAMPLE);
  localparam int BIT_CNT_W  = bit_cnt_width(DEF_DATA_BITS);

  // Expected parity bit: even parity is the XOR of the data; odd inverts it.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: oversampled start validation, mid-bit sampling, valid/ready output.
// Optional parity stage compiled in with `define UART_RX_PARITY_EN.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_baud_tick,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_error,
  output logic                 o_frame_error,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int SW = samp_cnt_width(OVERSAMPLE);
  localparam int BW = bit_cnt_width(DATA_BITS);
  localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  logic rx;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (rx)
  );

  rx_state_e            state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 frame_done;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
  logic                 pe_q, pe_d;
`endif

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q & ~i_ready;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
    pe_d       = pe_q;
`endif

    if (i_baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d = START;
            samp_d  = '0;
          end
        end
        START: begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (samp_q == SAMP_MID) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rx ? IDLE : DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        DATA: begin
          if (samp_q == SAMP_END) begin
            shift_d = {rx, shift_q[DATA_BITS-1:1]};
            samp_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (samp_q == SAMP_END) begin
            par_err_d = rx != calc_parity(MAX_DATA_BITS'(shift_q), PARITY_ODD[0]);
            samp_d    = '0;
            state_d   = STOP;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
`endif
        STOP: begin
          // Returning to IDLE at the stop midpoint lets a back-to-back start edge be seen.
          if (samp_q == SAMP_END) begin
            samp_d     = '0;
            state_d    = IDLE;
            frame_done = rx;
            fe_d       = ~rx;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (frame_done) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        pe_d    = par_err_q;
`endif
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_frame_error = fe_q;
  assign o_overrun     = ov_q;
  assign o_busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_error = pe_q;
`else
  assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed self-checking bench for uart_rx_sequencer (OVERSAMPLE=16, DATA_BITS=8, tick every cycle).
module tb_uart_rx_sequencer;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FULL      = NBITS * OS;
  // Edge (counted from the first driven start-bit cycle) at which the stop bit is sampled.
  localparam int STOP_EDGE = 11 + OS * (NBITS - 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx;
  logic       rdy;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_error;
  logic       o_frame_error;
  logic       o_overrun;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  uart_rx_sequencer #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .PARITY_ODD (0)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_baud_tick    (tick),
    .i_rx           (rx),
    .i_ready        (rdy),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_parity_error (o_parity_error),
    .o_frame_error  (o_frame_error),
    .o_overrun      (o_overrun),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  int         acc_cnt = 0;
  int         vcyc_cnt = 0;
  int         busy_cyc = 0;
  int         fe_cnt = 0;
  int         fe_run = 0;
  int         fe_max = 0;
  int         ov_cnt = 0;
  int         ov_run = 0;
  int         ov_max = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_pe = 1'b0;

  always @(negedge clk) begin
    if (o_valid && rdy) begin
      acc_cnt   <= acc_cnt + 1;
      last_data <= o_data;
      last_pe   <= o_parity_error;
      $display("accept data=%h pe=%0b t=%0t", o_data, o_parity_error, $time);
    end
    if (o_valid) vcyc_cnt <= vcyc_cnt + 1;
    if (o_busy) busy_cyc <= busy_cyc + 1;
    if (o_frame_error) begin
      fe_cnt <= fe_cnt + 1;
      fe_run <= fe_run + 1;
      if (fe_run + 1 > fe_max) fe_max <= fe_run + 1;
    end else begin
      fe_run <= 0;
    end
    if (o_overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_run <= ov_run + 1;
      if (ov_run + 1 > ov_max) ov_max <= ov_run + 1;
    end else begin
      ov_run <= 0;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives ncyc cycles of a frame; i_ready is pulsed high for the one cycle with index rdy_pulse.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input int ncyc, input int rdy_pulse);
    logic [10:0] bits;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_flip;
    bits[10] = stop;
`else
    bits[9] = stop;
    if (par_flip) bits[10] = 1'b1;
`endif
    for (int c = 0; c < ncyc; c++) begin
      rx = bits[c / OS];
      if (c == rdy_pulse) rdy = 1'b1;
      else if (c == rdy_pulse + 1) rdy = 1'b0;
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    $display("frame sent data=%h stop=%0b cycles=%0d", d, stop, ncyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; rx = 1'b1; rdy = 1'b0;
    idle(3);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", o_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if ({o_parity_error, o_frame_error, o_overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b exp=000", {o_parity_error, o_frame_error, o_overrun});
    end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single_frame();
    int a0, v0, f0, o0;
    a0 = acc_cnt; v0 = vcyc_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rdy = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, FULL, -5);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after_stop got=%b exp=0", o_busy); end
    idle(4);
    checks++; if (acc_cnt - a0 != 1) begin errors++; $display("FAIL a5_accepts got=%0d exp=1", acc_cnt - a0); end
    checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", last_data); end
    checks++; if (last_pe !== 1'b0) begin errors++; $display("FAIL a5_parity_err got=%b exp=0", last_pe); end
    checks++; if (vcyc_cnt - v0 != 1) begin errors++; $display("FAIL a5_valid_cycles got=%0d exp=1", vcyc_cnt - v0); end
    checks++; if ((fe_cnt - f0) + (ov_cnt - o0) != 0) begin
      errors++; $display("FAIL a5_no_status got=%0d exp=0", (fe_cnt - f0) + (ov_cnt - o0));
    end
  endtask

  task automatic test_glitch();
    int a0, b0, f0, o0;
    a0 = acc_cnt; b0 = busy_cyc; f0 = fe_cnt; o0 = ov_cnt;
    rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rx = 1'b0;
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    idle(20);
    $display("glitch 4 ticks busy_cycles=%0d", busy_cyc - b0);
    checks++; if (busy_cyc - b0 != 8) begin errors++; $display("FAIL glitch_start_cycles got=%0d exp=8", busy_cyc - b0); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle got=%b exp=0", o_busy); end
    checks++; if ((acc_cnt - a0) + (fe_cnt - f0) + (ov_cnt - o0) != 0) begin
      errors++; $display("FAIL glitch_no_output got=%0d exp=0", (acc_cnt - a0) + (fe_cnt - f0) + (ov_cnt - o0));
    end
  endtask

  task automatic test_frame_error();
    int a0, v0, f0;
    a0 = acc_cnt; v0 = vcyc_cnt; f0 = fe_cnt;
    rdy = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, FULL, -5);
    idle(24);
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL fe_pulse_count got=%0d exp=1", fe_cnt - f0); end
    checks++; if (fe_max != 1) begin errors++; $display("FAIL fe_pulse_width got=%0d exp=1", fe_max); end
    checks++; if ((vcyc_cnt - v0) + (acc_cnt - a0) != 0) begin
      errors++; $display("FAIL fe_no_valid got=%0d exp=0", (vcyc_cnt - v0) + (acc_cnt - a0));
    end
  endtask

  task automatic test_overrun();
    int a0, o0;
    a0 = acc_cnt; o0 = ov_cnt;
    rdy = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, FULL, -5);
    send_frame(8'h22, 1'b1, 1'b0, FULL, -5);
    idle(2);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got=%b exp=1", o_valid); end
    checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL ovr_data_held got=%h exp=11", o_data); end
    checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse_count got=%0d exp=1", ov_cnt - o0); end
    checks++; if (ov_max != 1) begin errors++; $display("FAIL ovr_pulse_width got=%0d exp=1", ov_max); end
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    checks++; if (acc_cnt - a0 != 1 || last_data !== 8'h11) begin
      errors++; $display("FAIL ovr_drain got=%0d/%h exp=1/11", acc_cnt - a0, last_data);
    end
    idle(1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got=%b exp=0", o_valid); end

    o0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, FULL, -5);
    send_frame(8'h22, 1'b1, 1'b0, FULL, STOP_EDGE - 1);
    idle(2);
    checks++; if (ov_cnt - o0 != 0) begin errors++; $display("FAIL same_cycle_no_overrun got=%0d exp=0", ov_cnt - o0); end
    checks++; if (o_data !== 8'h22 || o_valid !== 1'b1) begin
      errors++; $display("FAIL same_cycle_load got=%h/%b exp=22/1", o_data, o_valid);
    end
    checks++; if (last_data !== 8'h11) begin errors++; $display("FAIL same_cycle_accept got=%h exp=11", last_data); end
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    checks++; if (last_data !== 8'h22) begin errors++; $display("FAIL same_cycle_drain got=%h exp=22", last_data); end
    idle(2);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int a0;
    a0 = acc_cnt;
    rdy = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1, FULL, -5);
    idle(4);
    checks++; if (acc_cnt - a0 != 1 || last_data !== 8'h01) begin
      errors++; $display("FAIL par_bad_data got=%0d/%h exp=1/01", acc_cnt - a0, last_data);
    end
    checks++; if (last_pe !== 1'b1) begin errors++; $display("FAIL par_bad_flag got=%b exp=1", last_pe); end
    send_frame(8'h01, 1'b1, 1'b0, FULL, -5);
    idle(4);
    checks++; if (last_pe !== 1'b0) begin errors++; $display("FAIL par_good_flag got=%b exp=0", last_pe); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int a0;
    rdy = 1'b0;
    send_frame(8'h77, 1'b1, 1'b0, FULL, -5);
    send_frame(8'h5A, 1'b1, 1'b0, 70, -5);
    checks++; if (o_busy !== 1'b1 || o_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_busy_valid got=%b%b exp=11", o_busy, o_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%b exp=0/00/0", o_valid, o_data, o_busy);
    end
    checks++; if ({o_parity_error, o_frame_error, o_overrun} !== 3'b000) begin
      errors++; $display("FAIL async_reset_status got=%b exp=000", {o_parity_error, o_frame_error, o_overrun});
    end
    @(posedge clk);
    #1;
    rx = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    a0 = acc_cnt;
    rdy = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, FULL, -5);
    idle(4);
    checks++; if (acc_cnt - a0 != 1 || last_data !== 8'h5A) begin
      errors++; $display("FAIL post_reset_frame got=%0d/%h exp=1/5a", acc_cnt - a0, last_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
